// File: rtl/serial_adder_pkg.sv
// Shared types and width limits for the serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder: the single arithmetic slice of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_n.sv
// LSB-first serial adder, one bit per clock, with start/busy/done handshake.
// Define SERADD_SUB_EN to add the sub port (a - b - cin via inverted B and carry).
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [CW-1:0]    bit_idx
);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_n: WIDTH must be within 2..64");
    end
  endgenerate

  state_t           state_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CW-1:0]    idx_reg;

  logic             s_bit;
  logic             c_bit;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] opb_load;
  logic             carry_load;

`ifdef SERADD_SUB_EN
  assign opb_load   = sub ? ~b : b;
  assign carry_load = cin ^ sub;
`else
  assign opb_load   = b;
  assign carry_load = cin;
`endif

  fa_cell u_fa (
    .a  (opa_reg[0]),
    .b  (opb_reg[0]),
    .ci (carry_reg),
    .s  (s_bit),
    .co (c_bit)
  );

  // A start seen during RUN is dropped, never queued.
  assign accept   = start && (state_reg != RUN);
  assign last_bit = (idx_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      unique case (state_reg)
        RUN: begin
          acc_reg   <= {s_bit, acc_reg[WIDTH-1:1]};
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          carry_reg <= c_bit;
          if (last_bit) begin
            // carry_reg here is the carry into the MSB, so ovf is its XOR with carry-out.
            sum_reg   <= {s_bit, acc_reg[WIDTH-1:1]};
            cout_reg  <= c_bit;
            ovf_reg   <= carry_reg ^ c_bit;
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + CW'(1);
          end
        end
        default: begin
          if (accept) begin
            opa_reg   <= a;
            opb_reg   <= opb_load;
            carry_reg <= carry_load;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign sum     = sum_reg;
  assign cout    = cout_reg;
  assign ovf     = ovf_reg;
  assign bit_idx = idx_reg;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n at WIDTH 8, 2 and 64; sub tests need SERADD_SUB_EN.
module tb_serial_adder_n;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8;
  logic [2:0]  idx8;

  logic        start2, cin2;
  logic [1:0]  a2, b2, sum2;
  logic        busy2, done2, cout2, ovf2;
  logic [0:0]  idx2;

  logic        start64, cin64;
  logic [63:0] a64, b64, sum64;
  logic        busy64, done64, cout64, ovf64;
  logic [5:0]  idx64;

`ifdef SERADD_SUB_EN
  logic sub8, sub2, sub64;
`endif

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  int          sel_w;
  logic        obs_busy, obs_done, obs_cout, obs_ovf;
  logic [63:0] obs_sum;
  int          obs_idx;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .bit_idx(idx8)
  );

  serial_adder_n #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERADD_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2), .bit_idx(idx2)
  );

  serial_adder_n #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .cin(cin64),
`ifdef SERADD_SUB_EN
    .sub(sub64),
`endif
    .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .ovf(ovf64), .bit_idx(idx64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_sum  = {56'd0, sum8};
    obs_cout = cout8;
    obs_ovf  = ovf8;
    obs_idx  = int'(idx8);
    if (sel_w == 2) begin
      obs_busy = busy2;
      obs_done = done2;
      obs_sum  = {62'd0, sum2};
      obs_cout = cout2;
      obs_ovf  = ovf2;
      obs_idx  = int'(idx2);
    end else if (sel_w == 64) begin
      obs_busy = busy64;
      obs_done = done64;
      obs_sum  = sum64;
      obs_cout = cout64;
      obs_ovf  = ovf64;
      obs_idx  = int'(idx64);
    end
  end

  // Reference: wide arithmetic on the masked operands; ovf from carry into MSB vs out.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [64:0] mask, m1, full, low;
    logic [63:0] bb;
    logic        c0;
    mask  = (65'd1 << w) - 65'd1;
    m1    = (65'd1 << (w - 1)) - 65'd1;
    bb    = sub ? ~b : b;
    c0    = cin ^ sub;
    full  = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {64'd0, c0};
    low   = ({1'b0, a} & m1) + ({1'b0, bb} & m1) + {64'd0, c0};
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ full[w];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic st, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub);
    if (w == 2) begin
      start2 = st; a2 = a[1:0]; b2 = b[1:0]; cin2 = cin;
`ifdef SERADD_SUB_EN
      sub2 = sub;
`endif
    end else if (w == 64) begin
      start64 = st; a64 = a; b64 = b; cin64 = cin;
`ifdef SERADD_SUB_EN
      sub64 = sub;
`endif
    end else begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin;
`ifdef SERADD_SUB_EN
      sub8 = sub;
`endif
    end
    if (sub) begin
    end
  endtask

  // One full transaction on instance w: pulse start, wait for done, score it.
  task automatic run_op(input int w, input string name, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input logic sub);
    exp_t e;
    int   cyc, busy_cnt, idx_bad;
    logic got;
    sel_w = w;
    exp_q.push_back(model(w, a, b, cin, sub));
    drive(w, 1'b1, a, b, cin, sub);
    step();
    drive(w, 1'b0, ~a, ~b, ~cin, sub);
    cyc = 1; busy_cnt = 0; idx_bad = 0; got = 1'b0;
    while (cyc <= 3 * w + 10) begin
      if (obs_done) begin
        got = 1'b1;
        break;
      end
      if (obs_busy) busy_cnt++;
      if (obs_idx != cyc - 1) idx_bad++;
      step();
      cyc++;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: got no done after %0d cycles, want done at %0d", name, cyc, w + 1);
      return;
    end
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: got done with empty queue, want one pending result", name);
      return;
    end
    e = exp_q.pop_front();
    $display("txn %s: w=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d busy=%0d",
             name, w, a, b, cin, sub, obs_sum, obs_cout, obs_ovf, cyc, busy_cnt);
    if (cyc !== w + 1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, w + 1);
    end
    n_cmp++;
    if (busy_cnt !== w) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, w);
    end
    n_cmp++;
    if (idx_bad !== 0) begin
      n_bad++;
      $display("FAIL %s bit_idx: got %0d wrong samples want 0", name, idx_bad);
    end
    n_cmp++;
    if (obs_sum !== e.sum) begin
      n_bad++;
      $display("FAIL %s sum: got %h want %h", name, obs_sum, e.sum);
    end
    n_cmp++;
    if (obs_cout !== e.cout) begin
      n_bad++;
      $display("FAIL %s cout: got %b want %b", name, obs_cout, e.cout);
    end
    n_cmp++;
    if (obs_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL %s ovf: got %b want %b", name, obs_ovf, e.ovf);
    end
    step();
    n_cmp++;
    if ({obs_done, obs_busy} !== 2'b00 || obs_sum !== e.sum) begin
      n_bad++;
      $display("FAIL %s after_done: got done=%b busy=%b sum=%h want done=0 busy=0 sum=%h",
               name, obs_done, obs_busy, obs_sum, e.sum);
    end
  endtask

  task automatic test_reset();
    sel_w = 8;
    rst = 1'b1;
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(64, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    $display("txn reset: busy=%b done=%b sum=%h cout=%b ovf=%b idx=%0d",
             busy8, done8, sum8, cout8, ovf8, idx8);
    n_cmp++;
    if ({busy8, done8, cout8, ovf8} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got busy,done,cout,ovf=%b want 0000", {busy8, done8, cout8, ovf8});
    end
    n_cmp++;
    if (sum8 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_sum: got %h want 00", sum8);
    end
    n_cmp++;
    if (idx8 !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_bit_idx: got %0d want 0", idx8);
    end
  endtask

  task automatic test_add();
    run_op(8, "add_5a_3c", 64'h5A, 64'h3C, 1'b0, 1'b0);
    run_op(8, "add_ff_01", 64'hFF, 64'h01, 1'b0, 1'b0);
    run_op(8, "add_00_00_cin", 64'h00, 64'h00, 1'b1, 1'b0);
    run_op(8, "add_7f_7f_cin", 64'h7F, 64'h7F, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
`ifdef SERADD_SUB_EN
    run_op(8, "sub_10_20", 64'h10, 64'h20, 1'b0, 1'b1);
    run_op(8, "sub_80_01", 64'h80, 64'h01, 1'b0, 1'b1);
    run_op(8, "sub_05_03_bin", 64'h05, 64'h03, 1'b1, 1'b1);
`endif
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   ndone;
    sel_w = 8;
    exp_q.push_back(model(8, 64'h5A, 64'h3C, 1'b0, 1'b0));
    drive(8, 1'b1, 64'h5A, 64'h3C, 1'b0, 1'b0);
    step();
    drive(8, 1'b0, 64'h00, 64'h00, 1'b0, 1'b0);
    ndone = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (done8) begin
        ndone++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("txn ignored_start: sum=%h cout=%b ovf=%b at cycle %0d", sum8, cout8, ovf8, cyc);
          n_cmp++;
          if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
            n_bad++;
            $display("FAIL ignored_start_result: got %h/%b/%b want %h/%b/%b",
                     sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
          end
        end
      end
      if (cyc == 3) drive(8, 1'b1, 64'hFF, 64'hFF, 1'b1, 1'b0);
      if (cyc == 4) drive(8, 1'b0, 64'h00, 64'h00, 1'b0, 1'b0);
      step();
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_bad++;
      $display("FAIL ignored_start_pulses: got %0d done pulses want 1", ndone);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   ndone, first_cyc, second_cyc;
    sel_w = 8;
    first_cyc = 0; second_cyc = 0; ndone = 0;
    exp_q.push_back(model(8, 64'h12, 64'h34, 1'b1, 1'b0));
    drive(8, 1'b1, 64'h12, 64'h34, 1'b1, 1'b0);
    step();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done8) begin
        ndone++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("txn back_to_back_%0d: sum=%h cout=%b ovf=%b at cycle %0d",
                   ndone, sum8, cout8, ovf8, cyc);
          n_cmp++;
          if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
            n_bad++;
            $display("FAIL back_to_back_result_%0d: got %h/%b/%b want %h/%b/%b",
                     ndone, sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
          end
        end
        if (ndone == 1) begin
          first_cyc = cyc;
          exp_q.push_back(model(8, 64'hF0, 64'h20, 1'b0, 1'b0));
          drive(8, 1'b1, 64'hF0, 64'h20, 1'b0, 1'b0);
        end else begin
          second_cyc = cyc;
          drive(8, 1'b0, 64'h00, 64'h00, 1'b0, 1'b0);
          break;
        end
      end
      step();
    end
    n_cmp++;
    if (ndone !== 2 || second_cyc - first_cyc !== 9) begin
      n_bad++;
      $display("FAIL back_to_back_spacing: got %0d pulses spaced %0d want 2 pulses spaced 9",
               ndone, second_cyc - first_cyc);
    end
    drive(8, 1'b0, 64'h00, 64'h00, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({busy8, done8} !== 2'b00) begin
      n_bad++;
      $display("FAIL back_to_back_idle: got busy=%b done=%b want 0 0", busy8, done8);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int ndone;
    sel_w = 8;
    drive(8, 1'b1, 64'hFF, 64'h01, 1'b0, 1'b0);
    step();
    drive(8, 1'b0, 64'h00, 64'h00, 1'b0, 1'b0);
    for (int cyc = 1; cyc < 5; cyc++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("txn reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b idx=%0d",
             busy8, done8, sum8, cout8, ovf8, idx8);
    n_cmp++;
    if ({busy8, done8, cout8, ovf8} !== 4'b0000 || idx8 !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_mid_flags: got busy,done,cout,ovf=%b idx=%0d want 0000 idx=0",
               {busy8, done8, cout8, ovf8}, idx8);
    end
    n_cmp++;
    if (sum8 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_sum: got %h want 00", sum8);
    end
    ndone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done8) ndone++;
      step();
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d done pulses want 0", ndone);
    end
    run_op(8, "after_reset_5a_3c", 64'h5A, 64'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_widths();
    run_op(2, "w2_01_01", 64'h1, 64'h1, 1'b0, 1'b0);
    run_op(2, "w2_11_01", 64'h3, 64'h1, 1'b0, 1'b0);
    run_op(64, "w64_5a_3c", 64'h5A, 64'h3C, 1'b0, 1'b0);
    run_op(64, "w64_max_pos_inc", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op(64, "w64_all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel_w = 8;
    test_reset();
    test_add();
    test_sub();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_widths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised LSB-first serial adder/subtractor with a start/busy/done handshake. It latches two WIDTH-bit parallel operands and processes one bit per clock through a single full-adder cell. It presents the registered sum, carry-out and signed overflow when the operation completes. It is the general-width, handshaked successor to the fixed 4-bit serial adder in the arithmetic datapath blocks.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..64.
- CW, $clog2(WIDTH): bit-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when state is IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in (borrow-in in subtract mode); sampled on the accepting edge.
- sub  in  1  subtract mode (present only with SERADD_SUB_EN); sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE; sum, cout and ovf are valid from this cycle onward.
- sum  out  WIDTH  result; holds its value until the next completion.
- cout  out  1  final carry-out. In subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- bit_idx  out  CW  index of the bit being processed in RUN; 0 otherwise.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after bit WIDTH-1 is processed.
  - DONE→RUN if start is high in DONE (back-to-back); otherwise DONE→IDLE.
- On an accepting edge:
  - opa←a; opb←b (or ~b when sub=1).
  - carry←cin^sub (cin without the macro).
  - bit_idx←0; the internal accumulator is cleared.
- Each RUN edge:
  - s = opa[0]^opb[0]^carry; c = majority(opa[0], opb[0], carry).
  - The accumulator shifts right with s entering at the MSB.
  - opa and opb shift right; carry←c; bit_idx increments.
- On the final RUN edge (bit_idx==WIDTH-1):
  - sum←{s, acc[WIDTH-1:1]}; cout←c; ovf←carry^c (carry is the carry into the MSB).
  - State→DONE.
- start during RUN is ignored and does not queue.
- sum, cout and ovf never show partial results. They change only on the final RUN edge.
- Reset mid-operation aborts immediately with no done pulse, and every output returns to its reset value.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, bit_idx=0, state=IDLE.

## Timing
- Accepting edge E0. busy is high from E0 through E0+WIDTH edges (WIDTH cycles).
- done is high for exactly the one cycle after edge E0+WIDTH. Start-to-done latency is WIDTH+1 cycles from the cycle in which start is asserted.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- Operands may change freely after E0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERADD_SUB_EN defined:
  - The sub port exists.
  - sub=1 computes a − b − cin: B is inverted and the initial carry is ~cin.
  - cout is the no-borrow flag.
- SERADD_SUB_EN undefined:
  - The sub port is removed; the block is add-only with initial carry = cin.
  - The inverter and XOR logic are not synthesised.

## Structure
- serial_adder_pkg holds:
  - the state_t enum (IDLE, RUN, DONE);
  - the constants MIN_WIDTH=2 and MAX_WIDTH=64, used by an elaboration-time WIDTH range check.
- Sub-module fa_cell: combinational 1-bit full adder (a, b, ci → s, co), instanced once for the serial bit slice.
- All sequential logic lives in serial_adder_n. Expected size is about 150–250 lines.

## Test plan
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0: done 9 cycles after start; sum=8'h96, cout=0, ovf=1; busy high exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Then a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0.
- SERADD_SUB_EN, sub=1, a=8'h10, b=8'h20, cin=0 → sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, ovf=1, cout=1.
- start pulsed again at RUN cycle 3 with different operands: ignored; the result matches the first operation and only one done pulse occurs.
- start held high through DONE: a second operation starts with no IDLE cycle, and done pulses recur every 9 cycles.
- rst asserted at RUN cycle 5: the next cycle shows state IDLE, busy=0, sum=0, and no done pulse. A following start completes correctly. Repeat the first scenario with WIDTH=2 and WIDTH=64.
